// File: rtl/fn_to_rec_fn_arbiter_if.sv
// Handshake bundle for fn_to_rec_fn_arbiter.
//   master : requester/consumer side (drives req_valid, req_data, resp_ready)
//   slave  : the arbiter (drives req_ready and the registered response)
// Ports carried:
//   req_valid/req_data/req_ready : per-requester operand handshake; slice i of
//                                  req_data is requester i's IEEE operand
//   resp_valid/resp_ready        : single downstream result handshake
//   resp_data/resp_id            : recoded result and the requester it came from
//   resp_is_zero/inf/nan         : class flags taken from the recoded exponent
interface fn_to_rec_fn_arbiter_if #(
    parameter int expWidth = 8,
    parameter int sigWidth = 24,
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
);
    logic [NUM_REQ-1:0]                        req_valid;
    logic [NUM_REQ*(expWidth+sigWidth)-1:0]    req_data;
    logic [NUM_REQ-1:0]                        req_ready;
    logic                                      resp_valid;
    logic                                      resp_ready;
    logic [expWidth+sigWidth:0]                resp_data;
    logic [ID_WIDTH-1:0]                       resp_id;
    logic                                      resp_is_zero;
    logic                                      resp_is_inf;
    logic                                      resp_is_nan;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id,
               resp_is_zero, resp_is_inf, resp_is_nan
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id,
               resp_is_zero, resp_is_inf, resp_is_nan
    );
endinterface

// File: rtl/fn_to_rec_fn_arbiter.sv
// Round-robin shared IEEE -> recoded float converter.
//   fn_to_rec_fn         : combinational IEEE-to-recoded-format conversion
//   fn_to_rec_fn_arbiter : picks one valid requester per cycle (round robin),
//                          converts its operand and registers the result with
//                          the requester ID and class flags until consumed.
// Ports (fn_to_rec_fn_arbiter):
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : slave side of fn_to_rec_fn_arbiter_if (requests in, result out)

module fn_to_rec_fn #(
    parameter int expWidth = 8,
    parameter int sigWidth = 24
) (
    input  logic [expWidth+sigWidth-1:0] in_f,
    output logic [expWidth+sigWidth:0]   out_rec
);
    localparam int W      = expWidth + sigWidth;
    localparam int NORM_W = $clog2(sigWidth - 1);
    // 2^(expWidth-1): recoded exponent bias offset relative to the IEEE one
    localparam logic [expWidth:0] EXP_BIAS = {1'b0, 1'b1, {(expWidth-1){1'b0}}};

    logic                  sign;
    logic [expWidth-1:0]   exp_in;
    logic [sigWidth-2:0]   fract;
    logic                  is_zero_exp;
    logic                  is_zero_fract;
    logic                  is_zero;
    logic                  is_special;
    logic [NORM_W-1:0]     norm_dist;
    logic [sigWidth-2:0]   shifted;
    logic [sigWidth-2:0]   subnorm_fract;
    logic [expWidth:0]     adj_src;
    logic [expWidth:0]     adj_exp;
    logic [2:0]            exp_top;
    logic [expWidth-3:0]   exp_low;

    assign sign          = in_f[W-1];
    assign exp_in        = in_f[W-2 -: expWidth];
    assign fract         = in_f[sigWidth-2:0];
    assign is_zero_exp   = (exp_in == '0);
    assign is_zero_fract = (fract == '0);
    assign is_zero       = is_zero_exp && is_zero_fract;

    // Leading-zero count of the fraction; the highest set bit wins because
    // the loop runs upward and later assignments override earlier ones.
    always_comb begin
        norm_dist = '0;
        for (int i = 0; i < sigWidth - 1; i++) begin
            if (fract[i]) begin
                norm_dist = NORM_W'(sigWidth - 2 - i);
            end
        end
    end

    // Normalising shift drops the leading one, which becomes implicit.
    assign shifted       = fract << norm_dist;
    assign subnorm_fract = {shifted[sigWidth-3:0], 1'b0};

    // Subnormals take an exponent below the normal range: ~norm_dist + bias + 2.
    assign adj_src = is_zero_exp ? ~{{(expWidth+1-NORM_W){1'b0}}, norm_dist}
                                 : {1'b0, exp_in};
    assign adj_exp = adj_src + EXP_BIAS
                   + (is_zero_exp ? (expWidth+1)'(2) : (expWidth+1)'(1));

    assign is_special = (adj_exp[expWidth -: 2] == 2'b11);

    // Zero is emitted with a fully cleared exponent so a zero input gives an
    // all-zero recoded word (apart from the sign).
    assign exp_top = is_special ? {2'b11, !is_zero_fract}
                   : is_zero    ? 3'b000
                   : adj_exp[expWidth -: 3];
    assign exp_low = is_zero ? '0 : adj_exp[expWidth-3:0];

    assign out_rec = {sign, exp_top, exp_low, is_zero_exp ? subnorm_fract : fract};
endmodule

module fn_to_rec_fn_arbiter #(
    parameter int expWidth = 8,
    parameter int sigWidth = 24,
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    fn_to_rec_fn_arbiter_if.slave  bus
);
    localparam int W = expWidth + sigWidth;

    logic [ID_WIDTH-1:0] ptr_reg, ptr_next;
    logic [ID_WIDTH-1:0] grant;
    logic                grant_found;
    logic                slot_free;
    logic                accept;
    logic [W-1:0]        sel_data;
    logic [W:0]          rec_data;

    logic                resp_valid_reg;
    logic [W:0]          resp_data_reg;
    logic [ID_WIDTH-1:0] resp_id_reg;
    logic                resp_is_zero_reg;
    logic                resp_is_inf_reg;
    logic                resp_is_nan_reg;

    // A new result may enter when the register is empty or being drained now.
    assign slot_free = !resp_valid_reg || bus.resp_ready;

    // Rotating priority search starting at the pointer.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = ID_WIDTH'(idx);
            end
        end
    end

    // The grant is by construction a valid requester, so accept needs no
    // extra req_valid term.
    assign accept = reset && grant_found && slot_free;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = accept && (grant == ID_WIDTH'(gi));
        end
    endgenerate

    assign sel_data = bus.req_data[int'(grant)*W +: W];

    fn_to_rec_fn #(
        .expWidth (expWidth),
        .sigWidth (sigWidth)
    ) u_conv (
        .in_f    (sel_data),
        .out_rec (rec_data)
    );

    always_comb begin
        ptr_next = ptr_reg;
        if (accept) begin
            ptr_next = (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_reg          <= '0;
            resp_valid_reg   <= 1'b0;
            resp_data_reg    <= '0;
            resp_id_reg      <= '0;
            resp_is_zero_reg <= 1'b0;
            resp_is_inf_reg  <= 1'b0;
            resp_is_nan_reg  <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
            if (accept) begin
                resp_valid_reg   <= 1'b1;
                resp_data_reg    <= rec_data;
                resp_id_reg      <= grant;
                resp_is_zero_reg <= (rec_data[W-1 -: 3] == 3'b000);
                resp_is_inf_reg  <= (rec_data[W-1 -: 3] == 3'b110);
                resp_is_nan_reg  <= (rec_data[W-1 -: 3] == 3'b111);
            end else if (bus.resp_ready) begin
                resp_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.resp_valid   = resp_valid_reg;
    assign bus.resp_data    = resp_data_reg;
    assign bus.resp_id      = resp_id_reg;
    assign bus.resp_is_zero = resp_is_zero_reg;
    assign bus.resp_is_inf  = resp_is_inf_reg;
    assign bus.resp_is_nan  = resp_is_nan_reg;
endmodule

// File: tb/tb_fn_to_rec_fn_arbiter.sv
// Testbench for fn_to_rec_fn_arbiter: directed operands with hand-computed
// recoded results; accepted requests push expectations into a scoreboard and
// a negedge monitor pops and compares every consumed response.
module tb_fn_to_rec_fn_arbiter;
    localparam int EW = 8;
    localparam int SW = 24;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int W  = EW + SW;

    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_ZERO = 3'b001;  // {nan, inf, zero}
    localparam logic [2:0] F_INF  = 3'b010;
    localparam logic [2:0] F_NAN  = 3'b100;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W:0]    data;
        logic [2:0]    flags;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fn_to_rec_fn_arbiter_if #(.expWidth(EW), .sigWidth(SW), .NUM_REQ(NR), .ID_WIDTH(IW)) bus();

    fn_to_rec_fn_arbiter #(.expWidth(EW), .sigWidth(SW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    // Round-robin table: grant order, operands and recoded results.
    int          rr_g   [5] = '{0, 1, 2, 3, 0};
    logic [31:0] rr_in  [5] = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F000000, 32'hC0000000};
    logic [32:0] rr_exp [5] = '{33'h080000000, 33'h080800000, 33'h180000000, 33'h07F800000, 33'h180800000};

    // Special values from requester 0.
    logic [31:0] sp_in  [3] = '{32'h00000000, 32'h7F800000, 32'h7FC00000};
    logic [32:0] sp_exp [3] = '{33'h000000000, 33'h0C0000000, 33'h0E0400000};
    logic [2:0]  sp_flg [3] = '{F_ZERO, F_INF, F_NAN};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [31:0] d);
        bus.req_valid[r]          = 1'b1;
        bus.req_data[r*W +: W]    = d;
    endtask

    task automatic clr_req(input int r);
        bus.req_valid[r] = 1'b0;
    endtask

    // Check req_ready this cycle and record the expected response.
    task automatic expect_grant(input string name, input logic [3:0] exp_ready,
                                input int id, input logic [32:0] d, input logic [2:0] f);
        exp_t e;
        @(negedge clk);
        chk(name, 64'(bus.req_ready), 64'(exp_ready));
        e.id    = IW'(id);
        e.data  = d;
        e.flags = f;
        sb_q.push_back(e);
        $display("accept %s: req_ready=%b id=%0d expect 0x%09h", name, bus.req_ready, id, d);
    endtask

    // Scoreboard monitor: compares each consumed response.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_resp: got id %0d data 0x%09h, expected no response",
                         bus.resp_id, bus.resp_data);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp_data", 64'(bus.resp_data), 64'(mon_e.data));
                chk("resp_id", 64'(bus.resp_id), 64'(mon_e.id));
                chk("resp_flags", 64'({bus.resp_is_nan, bus.resp_is_inf, bus.resp_is_zero}),
                    64'(mon_e.flags));
                $display("resp id=%0d data=0x%09h flags(nan,inf,zero)=%b",
                         bus.resp_id, bus.resp_data,
                         {bus.resp_is_nan, bus.resp_is_inf, bus.resp_is_zero});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, with requester 2 already presenting 1.0.
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b1;
        set_req(2, 32'h3F800000);
        step();
        step();
        @(negedge clk);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        chk("rst_resp_data", 64'(bus.resp_data), 64'(0));
        chk("rst_resp_id", 64'(bus.resp_id), 64'(0));
        chk("rst_flags", 64'({bus.resp_is_nan, bus.resp_is_inf, bus.resp_is_zero}), 64'(0));
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));

        // Single request from requester 2.
        step();
        rst_n = 1'b1;
        expect_grant("single_r2", 4'b0100, 2, 33'h080000000, F_NONE);
        step();
        clr_req(2);
        @(negedge clk);
        chk("single_latency_valid", 64'(bus.resp_valid), 64'(1));

        // Special values back to back from requester 0 (pointer now 3 -> 0 wins).
        step();
        for (int k = 0; k < 3; k++) begin
            set_req(0, sp_in[k]);
            expect_grant("special_r0", 4'b0001, 0, sp_exp[k], sp_flg[k]);
            step();
        end
        clr_req(0);

        // -inf from requester 3 alone moves the pointer back to 0.
        set_req(3, 32'hFF800000);
        expect_grant("neg_inf_r3", 4'b1000, 3, 33'h1C0000000, F_INF);
        step();
        clr_req(3);

        // Round robin with all four requesters valid.
        for (int r = 0; r < NR; r++) set_req(r, rr_in[r]);
        for (int k = 0; k < 5; k++) begin
            expect_grant("round_robin", 4'(1 << rr_g[k]), rr_g[k], rr_exp[k], F_NONE);
            step();
            if (k == 0) set_req(0, rr_in[4]);
            else clr_req(rr_g[k]);
        end
        step();  // let the last round-robin result drain

        // Backpressure: requester 1 result held while requester 2 waits.
        bus.resp_ready = 1'b0;
        set_req(1, 32'h40000000);
        expect_grant("bp_first_r1", 4'b0010, 1, 33'h080800000, F_NONE);
        step();
        clr_req(1);
        set_req(2, 32'hBF800000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_req_ready", 64'(bus.req_ready), 64'(0));
            chk("bp_resp_valid", 64'(bus.resp_valid), 64'(1));
            chk("bp_resp_data", 64'(bus.resp_data), 64'(33'h080800000));
            chk("bp_resp_id", 64'(bus.resp_id), 64'(1));
            step();
        end
        bus.resp_ready = 1'b1;
        expect_grant("bp_release_r2", 4'b0100, 2, 33'h180000000, F_NONE);
        step();
        clr_req(2);
        step();  // drain

        // Reset mid-stream: held result from requester 1, requesters 0 and 3 pending.
        bus.resp_ready = 1'b0;
        set_req(1, 32'h3F800000);
        expect_grant("pre_reset_r1", 4'b0010, 1, 33'h080000000, F_NONE);
        step();
        clr_req(1);
        set_req(0, 32'h40000000);
        set_req(3, 32'h3F000000);
        rst_n = 1'b0;
        @(negedge clk);
        chk("in_reset_req_ready", 64'(bus.req_ready), 64'(0));
        step();
        rst_n          = 1'b1;
        bus.resp_ready = 1'b1;
        sb_q.delete();  // the held result is discarded by reset
        @(negedge clk);
        chk("post_reset_valid", 64'(bus.resp_valid), 64'(0));
        sb_q.push_back('{id: 2'd0, data: 33'h080800000, flags: F_NONE});
        chk("post_reset_ready", 64'(bus.req_ready), 64'(4'b0001));
        $display("accept post_reset: req_ready=%b id=0", bus.req_ready);
        step();
        clr_req(0);
        expect_grant("post_reset_r3", 4'b1000, 3, 33'h07F800000, F_NONE);
        step();
        clr_req(3);

        // Subnormals: smallest positive and -2^-127.
        set_req(2, 32'h00000001);
        expect_grant("subnormal_min", 4'b0100, 2, 33'h035800000, F_NONE);
        step();
        clr_req(2);
        set_req(1, 32'h80400000);
        expect_grant("subnormal_neg", 4'b0010, 1, 33'h140800000, F_NONE);
        step();
        clr_req(1);

        step();
        step();
        @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
